// File: rtl/led_ctrl_multi_if.sv
// rtl/led_ctrl_multi_if.sv - Avalon-MM register port bundle for led_ctrl_multi
interface led_ctrl_multi_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] amm_address_i;
   logic [31:0]       amm_writedata_i;
   logic              amm_read_i;
   logic              amm_write_i;
   logic [31:0]       amm_readdata_o;
   logic              amm_readdatavalid_o;
   logic              amm_waitrequest_o;

   modport slave (
      input  amm_address_i, amm_writedata_i, amm_read_i, amm_write_i,
      output amm_readdata_o, amm_readdatavalid_o, amm_waitrequest_o
   );

   modport master (
      output amm_address_i, amm_writedata_i, amm_read_i, amm_write_i,
      input  amm_readdata_o, amm_readdatavalid_o, amm_waitrequest_o
   );
endinterface

// File: rtl/led_ctrl_multi.sv
// rtl/led_ctrl_multi.sv - multi-channel LED controller (off/on/blink/PWM) with Avalon-MM registers
// Optional STATUS register at the top word address is built when LED_CTRL_STATUS_EN is defined.
module led_ctrl_multi #(
   parameter int CLOCK_FREQ_MHZ = 100,
   parameter int CH_CNT         = 4,
   parameter int PWM_W          = 8,
   parameter int ADDR_W         = 4
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   led_ctrl_multi_if.slave   amm,
   output logic [CH_CNT-1:0] led_o
);
   localparam int PRESC_N = CLOCK_FREQ_MHZ * 1000;
   localparam int PRESC_W = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
   localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(PRESC_N - 1);
   localparam logic [31:0] ID_VAL  = 32'h4C45_0000 | {24'd0, 8'(CH_CNT)};
   localparam logic [31:0] CH_MASK = 32'hFFFF_FF03;

   logic [1:0]          rst_sync;
   logic                rst_n;
   logic [PRESC_W-1:0]  presc;
   logic                tick;
   logic [PWM_W-1:0]    pwm_cnt;
   logic                enable;
   logic [31:0]         ch_reg    [CH_CNT];
   logic [15:0]         blink_cnt [CH_CNT];
   logic [15:0]         half_m1   [CH_CNT];
   logic [CH_CNT-1:0]   phase;
   logic [CH_CNT-1:0]   lit;
   logic                wr_global;
   logic                restart;
   logic [CH_CNT-1:0]   wr_ch;
   logic                wr_blink;
   logic [31:0]         rd_mux;

   // Assert immediately, release two clocks after arst_n_i rises.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) rst_sync <= 2'b00;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];
   assign amm.amm_waitrequest_o = ~rst_n;

   assign tick = (presc == PRESC_TC);

`ifdef LED_CTRL_STATUS_EN
   logic [15:0] ms_cnt;
   logic [31:0] status;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)    ms_cnt <= '0;
      else if (tick) ms_cnt <= ms_cnt + 16'd1;
   end
   assign status = {ms_cnt, 16'(led_o)};
`endif

   always_comb begin
      wr_global = amm.amm_write_i && (amm.amm_address_i == ADDR_W'(1));
      restart   = wr_global && amm.amm_writedata_i[1];
      wr_blink  = (amm.amm_writedata_i[1:0] == 2'd2);
      rd_mux    = '0;
      if (amm.amm_address_i == '0)
         rd_mux = ID_VAL;
      else if (amm.amm_address_i == ADDR_W'(1))
         rd_mux = {31'd0, enable};
`ifdef LED_CTRL_STATUS_EN
      else if (amm.amm_address_i == '1)
         rd_mux = status;
`endif
      for (int n = 0; n < CH_CNT; n++) begin
         wr_ch[n] = amm.amm_write_i && (int'(amm.amm_address_i) == n + 2);
         if (int'(amm.amm_address_i) == n + 2)
            rd_mux = ch_reg[n];
      end
   end

   // A half-period of 0 behaves as 1 ms.
   always_comb begin
      for (int n = 0; n < CH_CNT; n++) begin
         half_m1[n] = (ch_reg[n][31:16] == 16'd0) ? 16'd0 : ch_reg[n][31:16] - 16'd1;
         case (ch_reg[n][1:0])
            2'd0:    lit[n] = 1'b0;
            2'd1:    lit[n] = 1'b1;
            2'd2:    lit[n] = phase[n];
            default: lit[n] = (pwm_cnt < ch_reg[n][8 +: PWM_W]);
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         presc                   <= '0;
         pwm_cnt                 <= '0;
         enable                  <= 1'b1;
         phase                   <= '0;
         amm.amm_readdata_o      <= '0;
         amm.amm_readdatavalid_o <= 1'b0;
         for (int n = 0; n < CH_CNT; n++) begin
            ch_reg[n]    <= '0;
            blink_cnt[n] <= '0;
         end
      end else begin
         amm.amm_readdatavalid_o <= amm.amm_read_i;
         amm.amm_readdata_o      <= amm.amm_read_i ? rd_mux : '0;

         if (restart) begin
            presc   <= '0;
            pwm_cnt <= '0;
         end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
         end

         if (wr_global) enable <= amm.amm_writedata_i[0];

         for (int n = 0; n < CH_CNT; n++) begin
            if (wr_ch[n]) ch_reg[n] <= amm.amm_writedata_i & CH_MASK;
            if (restart || (wr_ch[n] && wr_blink)) begin
               blink_cnt[n] <= '0;
               phase[n]     <= 1'b1;
            end else if (tick) begin
               if (blink_cnt[n] >= half_m1[n]) begin
                  blink_cnt[n] <= '0;
                  phase[n]     <= ~phase[n];
               end else begin
                  blink_cnt[n] <= blink_cnt[n] + 16'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) led_o <= '0;
      else        led_o <= enable ? lit : '0;
   end
endmodule

// File: doc/led_ctrl_multi.md
Name: led_ctrl_multi

Overview:
Multi-channel successor to the single-LED flicker controller. Drives CH_CNT LED outputs, each independently set to off, on, blink (programmable half-period in ms) or PWM dimming (programmable duty). Software controls it through an Avalon-MM slave on the HPS lightweight register window. The outputs feed HPS loan-IO or FPGA pins at top level.

Parameters:
CLOCK_FREQ_MHZ, 100, clk_i frequency in MHz; ms prescaler terminal count = CLOCK_FREQ_MHZ*1000-1
CH_CNT, 4, number of LED channels, 1..13
PWM_W, 8, PWM counter/duty width, 1..8
ADDR_W, 4, Avalon word address width; register space 2**ADDR_W words

Ports:
clk_i  in  1  system clock
arst_n_i  in  1  asynchronous active-low reset
amm_address_i  in  ADDR_W  word address
amm_writedata_i  in  32  write data
amm_read_i  in  1  read strobe
amm_write_i  in  1  write strobe
amm_readdata_o  out  32  read data, valid with readdatavalid
amm_readdatavalid_o  out  1  one-cycle read response
amm_waitrequest_o  out  1  always 0 after reset; 1 while arst_n_i low
led_o  out  CH_CNT  LED drive, 1 = lit

Behaviour:
- Reset (async assert, sync-released internally by 2-flop synchroniser): led_o=0, readdata=0, readdatavalid=0, waitrequest=1; GLOBAL=0x1; all CHn=0; prescaler, PWM counter, blink counters and phases cleared.
- Register map (word addresses):
  0 ID, RO: 0x4C45_0000 | CH_CNT[7:0].
  1 GLOBAL: bit0 enable (RW), bit1 restart (WO, self-clearing, reads 0).
  2+n CHn, n<CH_CNT: [1:0] mode (0 off, 1 on, 2 blink, 3 pwm), [15:8] duty (upper 8-PWM_W bits ignored, read back as written), [31:16] half-period ms.
  Unmapped addresses: reads 0, writes ignored. Writes to ID ignored.
- Bus: every access accepted in the cycle presented (waitrequest=0). Read at edge N -> readdatavalid=1 and readdata valid for exactly cycle N+1; readdata returns to 0 otherwise. Simultaneous read+write same cycle: both accepted; read returns pre-write value.
- ms tick: prescaler counts 0..CLOCK_FREQ_MHZ*1000-1, tick=1 one cycle at terminal count, wraps to 0.
- PWM: shared free-running PWM_W-bit counter, increments every clk, wraps 2**PWM_W-1 -> 0. Channel lit when counter < duty. duty=0 -> never lit; duty=2**PWM_W-1 -> lit (2**PWM_W-1) of 2**PWM_W cycles.
- Blink: per-channel 16-bit ms counter and phase bit. On ms tick: if counter >= max(half_period,1)-1 then counter<=0, phase toggles; else counter++. Half-period 0 treated as 1. Writing CHn with mode=2 (any prior mode) clears counter, phase=1 (lit). Writing CHn while already mode 2 with only period changed also restarts.
- Restart (GLOBAL bit1 written 1): all blink counters cleared, all phases=1, PWM counter and prescaler cleared, same edge.
- Output: led_o[n] registered: enable & f(mode). Write at edge N updates register; led_o reflects it at edge N+1.
- enable=0: led_o all 0; blink/PWM counters keep running.
- Reset asserted mid-operation: all state to reset values immediately; in-flight read response dropped.

Optional Feature:
LED_CTRL_STATUS_EN: defined -> address 2**ADDR_W-1 is STATUS, RO: [CH_CNT-1:0] = live led_o, [31:16] = free-running ms counter since reset (wraps 0xFFFF->0). Not defined -> that address is unmapped (reads 0); no ms counter logic.

Test Plan:
- Reset then read addr 0 -> readdatavalid one cycle after read, readdata=0x4C45_0004; waitrequest 1 during reset, 0 after.
- CLOCK_FREQ_MHZ=1: write CH0=0x0003_0002 -> led_o[0]=1 one cycle after write, toggles every 3000 clk (3 ms), 50% duty over 12 ms.
- Write CH1=0x0000_4003 (duty 64) -> led_o[1] high exactly 64 of every 256 cycles; duty 0 -> always 0; duty 0xFF -> 255/256.
- Write CH2=1, then GLOBAL=0 -> led_o[2] falls one cycle after write; GLOBAL=1 -> rises again; GLOBAL readback 0x1 (bit1 reads 0).
- Two channels blinking with periods 2 and 5 ms, write GLOBAL=0x3 -> both lit next cycle, phases aligned; read addr 9 and write addr 2 same cycle -> read returns 0, old CH0 value on concurrent read of addr 2.
- Assert arst_n_i mid-blink and during pending read -> led_o=0 immediately, no readdatavalid; with LED_CTRL_STATUS_EN, read addr 15 after 5 ms -> [31:16]=5, [3:0]=led_o.
